// File: rtl/impulse_stim_gen.sv
// Impulse / step / PRBS stimulus generator with a capture window that is aligned
// to the active stimulus samples. Single-shot or periodic runs.
module impulse_stim_gen #(
  parameter int WIDTH   = 18,
  parameter int AMP     = int'(18'sh18000),
  parameter int OFFSET  = 29,
  parameter int CAP_LEN = 128,
  parameter int PERIOD  = 512,
  localparam int CW     = $clog2(PERIOD)
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    sam_clk_en,
  input  logic                    sym_clk_en,
  input  logic                    start,
  input  logic                    stop,
  input  logic [1:0]              mode,
  output logic signed [WIDTH-1:0] stimulus,
  output logic                    cap_valid,
  output logic [CW-1:0]           cap_index,
  output logic                    busy,
  output logic                    done
);

  localparam logic signed [WIDTH-1:0] AMP_W = WIDTH'(AMP);
  localparam logic signed [WIDTH-1:0] AMP3  = AMP_W / WIDTH'(32'sd3);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEAD   = 2'd1,
    ACTIVE = 2'd2,
    TAIL   = 2'd3
  } state_t;

  state_t                  state_r;
  logic [CW-1:0]           cnt_r;
  logic [CW-1:0]           cap_index_r;
  logic [1:0]              mode_r;
  logic [8:0]              lfsr_r;
  logic [8:0]              lfsr_next_s;
  logic signed [WIDTH-1:0] stimulus_r;
  logic                    cap_valid_r;
  logic                    done_r;

  // 4-level symbol map: 00 -> +A, 01 -> +A/3, 10 -> -A/3, 11 -> -A
  function automatic logic signed [WIDTH-1:0] prbs_level(input logic [1:0] sym);
    case (sym)
      2'b00:   return AMP_W;
      2'b01:   return AMP3;
      2'b10:   return -AMP3;
      default: return -AMP_W;
    endcase
  endfunction

  // x^9 + x^5 + 1 Fibonacci shift, feedback enters at bit 0
  assign lfsr_next_s = {lfsr_r[7:0], lfsr_r[8] ^ lfsr_r[4]};

  // Run sequencer: every state and counter update is gated by the sample tick
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= CW'(0);
      cap_index_r <= CW'(0);
      mode_r      <= 2'd0;
      lfsr_r      <= 9'h1FF;
      stimulus_r  <= WIDTH'(0);
      cap_valid_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (sam_clk_en) begin
        if (stop && (state_r != IDLE)) begin
          state_r     <= IDLE;
          cnt_r       <= CW'(0);
          cap_index_r <= CW'(0);
          stimulus_r  <= WIDTH'(0);
          cap_valid_r <= 1'b0;
          done_r      <= 1'b1;
        end else begin
          case (state_r)
            IDLE: begin
              if (start && !stop) begin
                state_r <= LEAD;
                cnt_r   <= CW'(0);
                mode_r  <= mode;
                lfsr_r  <= 9'h1FF;
              end
            end
            LEAD: begin
              cnt_r <= cnt_r + CW'(1);
              if (cnt_r == CW'(OFFSET - 1)) begin
                state_r     <= ACTIVE;
                cap_valid_r <= 1'b1;
                cap_index_r <= CW'(0);
                stimulus_r  <= (mode_r == 2'd3) ? prbs_level(lfsr_r[1:0]) : AMP_W;
              end
            end
            ACTIVE: begin
              if (cap_index_r == CW'(CAP_LEN - 1)) begin
                cap_valid_r <= 1'b0;
                cap_index_r <= CW'(0);
                stimulus_r  <= WIDTH'(0);
                if (mode_r == 2'd1) begin
                  // a window ending on the last frame slot goes straight to the next lead
                  if (cnt_r == CW'(PERIOD - 1)) begin
                    cnt_r   <= CW'(0);
                    state_r <= LEAD;
                  end else begin
                    cnt_r   <= cnt_r + CW'(1);
                    state_r <= TAIL;
                  end
                end else begin
                  cnt_r   <= CW'(0);
                  state_r <= IDLE;
                  done_r  <= 1'b1;
                end
              end else begin
                cap_index_r <= cap_index_r + CW'(1);
                cnt_r       <= cnt_r + CW'(1);
                case (mode_r)
                  2'd2: stimulus_r <= AMP_W;
                  2'd3: begin
                    if (sym_clk_en) begin
                      lfsr_r     <= lfsr_next_s;
                      stimulus_r <= prbs_level(lfsr_next_s[1:0]);
                    end
                  end
                  default: stimulus_r <= WIDTH'(0);
                endcase
              end
            end
            TAIL: begin
              if (cnt_r == CW'(PERIOD - 1)) begin
                cnt_r   <= CW'(0);
                state_r <= LEAD;
              end else begin
                cnt_r <= cnt_r + CW'(1);
              end
            end
            default: state_r <= IDLE;
          endcase
        end
      end
    end
  end

  assign stimulus  = stimulus_r;
  assign cap_valid = cap_valid_r;
  assign cap_index = cap_index_r;
  assign busy      = (state_r != IDLE);
  assign done      = done_r;

endmodule

// File: tb/tb_impulse_stim_gen.sv
// Randomised self-checking bench for impulse_stim_gen; expected outputs come from
// a tick-indexed arithmetic model of a run (position in frame -> outputs).
module tb_impulse_stim_gen;

  localparam logic signed [17:0] AMP = 18'sd98304;
  localparam int OFF = 29;
  localparam int CAP = 128;
  localparam int PER = 512;

  logic               sys_clk = 1'b0;
  logic               reset;
  logic               sam_clk_en = 1'b0;
  logic               sym_clk_en = 1'b0;
  logic               start;
  logic               stop;
  logic [1:0]         mode;
  logic signed [17:0] stimulus;
  logic               cap_valid;
  logic [8:0]         cap_index;
  logic               busy;
  logic               done;
  logic               tick_sym;

  int errors = 0;
  int checks = 0;

  impulse_stim_gen dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .sam_clk_en(sam_clk_en),
    .sym_clk_en(sym_clk_en),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .stimulus  (stimulus),
    .cap_valid (cap_valid),
    .cap_index (cap_index),
    .busy      (busy),
    .done      (done)
  );

  always #5 sys_clk = ~sys_clk;

  // sample tick every 4 sys_clk, symbol tick on every 4th sample tick
  initial begin
    int cyc;
    int nsam;
    cyc  = 0;
    nsam = 0;
    forever begin
      @(negedge sys_clk);
      cyc++;
      sam_clk_en = (cyc % 4 == 0);
      if (sam_clk_en) nsam++;
      sym_clk_en = sam_clk_en && (nsam % 4 == 0);
    end
  end

  task automatic next_tick();
    do @(posedge sys_clk); while (sam_clk_en !== 1'b1);
    tick_sym = sym_clk_en;
    #1;
  endtask

  // symbol level after n LFSR advances from the 9'h1FF seed
  function automatic int level(input int n);
    logic [8:0] r;
    r = 9'h1FF;
    for (int i = 0; i < n; i++) r = {r[7:0], r[8] ^ r[4]};
    case (r[1:0])
      2'b00:   return 98304;
      2'b01:   return 32768;
      2'b10:   return -32768;
      default: return -98304;
    endcase
  endfunction

  // expected {stimulus, cap_valid, cap_index, busy, done} after tick k of a run (k=0 acceptance)
  function automatic logic [29:0] model(input int md, input int k, input int nsym);
    int p;
    int idx;
    logic signed [17:0] s;
    logic cv;
    logic b;
    logic d;
    p   = (md == 1) ? (k % PER) : k;
    cv  = (p >= OFF) && (p < OFF + CAP);
    idx = cv ? (p - OFF) : 0;
    b   = (md == 1) || (k < OFF + CAP);
    d   = (md != 1) && (k == OFF + CAP);
    if (!cv) s = 18'sd0;
    else if (md == 2) s = AMP;
    else if (md == 3) s = 18'(level(nsym));
    else s = (p == OFF) ? AMP : 18'sd0;
    return {s, cv, idx[8:0], b, d};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    stop  = 1'b0;
    mode  = 2'd0;
    repeat (3) next_tick();
    checks++;
    if ({stimulus, cap_valid, cap_index, busy, done} !== 30'd0)
      $display("FAIL reset_hold got=%h exp=%h", {stimulus, cap_valid, cap_index, busy, done}, 30'd0);
    start = 1'b0;
    #2 reset = 1'b0;
    repeat (2) next_tick();
    checks++;
    if ({stimulus, cap_valid, cap_index, busy, done} !== 30'd0) begin
      errors++;
      $display("FAIL reset_release_idle got=%h exp=%h", {stimulus, cap_valid, cap_index, busy, done}, 30'd0);
    end
  endtask

  task automatic test_single_impulse();
    logic [29:0] exp;
    int impulses;
    int noise_k;
    impulses = 0;
    noise_k  = $urandom_range(5, 140);
    repeat ($urandom_range(1, 6)) next_tick();
    mode  = 2'd0;
    start = 1'b1;
    next_tick();
    start = 1'b0;
    for (int k = 0; k <= OFF + CAP + 3; k++) begin
      if (k > 0) next_tick();
      start = (k == noise_k);
      exp = model(0, k, 0);
      checks++;
      if ({stimulus, cap_valid, cap_index, busy, done} !== exp) begin
        errors++;
        $display("FAIL single k=%0d got=%h exp=%h", k, {stimulus, cap_valid, cap_index, busy, done}, exp);
      end
      if (stimulus == AMP) impulses++;
      if (k == OFF + CAP) begin
        @(posedge sys_clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL single_done_width got=%b exp=0", done);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (impulses != 1) begin
      errors++;
      $display("FAIL single_impulse_count got=%0d exp=1", impulses);
    end
  endtask

  task automatic test_step();
    logic [29:0] exp;
    int amp_samples;
    amp_samples = 0;
    next_tick();
    mode  = 2'd2;
    start = 1'b1;
    next_tick();
    start = 1'b0;
    mode  = 2'($urandom_range(0, 3));
    for (int k = 0; k <= OFF + CAP + 2; k++) begin
      if (k > 0) next_tick();
      exp = model(2, k, 0);
      checks++;
      if ({stimulus, cap_valid, cap_index, busy, done} !== exp) begin
        errors++;
        $display("FAIL step k=%0d got=%h exp=%h", k, {stimulus, cap_valid, cap_index, busy, done}, exp);
      end
      if (stimulus == AMP) amp_samples++;
    end
    checks++;
    if (amp_samples != CAP) begin
      errors++;
      $display("FAIL step_amp_samples got=%0d exp=%0d", amp_samples, CAP);
    end
  endtask

  task automatic test_prbs();
    logic [29:0] exp;
    int nsym;
    nsym = 0;
    next_tick();
    mode  = 2'd3;
    start = 1'b1;
    next_tick();
    start = 1'b0;
    for (int k = 0; k <= OFF + CAP + 2; k++) begin
      if (k > 0) next_tick();
      if (k > OFF && k < OFF + CAP && tick_sym) nsym++;
      exp = model(3, k, nsym);
      checks++;
      if ({stimulus, cap_valid, cap_index, busy, done} !== exp) begin
        errors++;
        $display("FAIL prbs k=%0d sym=%0d got=%h exp=%h", k, nsym, {stimulus, cap_valid, cap_index, busy, done}, exp);
      end
      if (cap_valid === 1'b1) begin
        checks++;
        if (!(stimulus inside {18'sd98304, 18'sd32768, -18'sd32768, -18'sd98304})) begin
          errors++;
          $display("FAIL prbs_level k=%0d got=%0d exp=+-98304/+-32768", k, stimulus);
        end
      end
    end
    checks++;
    if (nsym < 8) begin
      errors++;
      $display("FAIL prbs_symbol_count got=%0d exp>=8", nsym);
    end
  endtask

  task automatic test_periodic();
    logic [29:0] exp;
    int k_stop;
    int impulses;
    impulses = 0;
    k_stop   = 2 * PER + OFF + $urandom_range(1, CAP - 10);
    next_tick();
    mode  = 2'd1;
    start = 1'b1;
    next_tick();
    for (int k = 0; k <= k_stop; k++) begin
      if (k > 0) next_tick();
      exp = model(1, k, 0);
      checks++;
      if ({stimulus, cap_valid, cap_index, busy, done} !== exp) begin
        errors++;
        $display("FAIL periodic k=%0d got=%h exp=%h", k, {stimulus, cap_valid, cap_index, busy, done}, exp);
      end
      if (stimulus == AMP) impulses++;
    end
    checks++;
    if (impulses != 3) begin
      errors++;
      $display("FAIL periodic_impulses got=%0d exp=3", impulses);
    end
    stop  = 1'b1;
    start = 1'b0;
    next_tick();
    checks++;
    if ({stimulus, cap_valid, busy, done} !== {18'sd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL periodic_stop got=%h exp=%h", {stimulus, cap_valid, busy, done}, {18'sd0, 1'b0, 1'b0, 1'b1});
    end
    @(posedge sys_clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL periodic_stop_done_width got=%b exp=0", done);
    end
    stop = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [29:0] exp;
    int k_rst;
    k_rst = $urandom_range(OFF + 1, OFF + CAP - 2);
    next_tick();
    mode  = 2'd0;
    start = 1'b1;
    next_tick();
    start = 1'b0;
    for (int k = 1; k <= k_rst; k++) next_tick();
    checks++;
    if (cap_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_active got=%b exp=1", cap_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({stimulus, cap_valid, cap_index, busy, done} !== 30'd0) begin
      errors++;
      $display("FAIL rst_async got=%h exp=%h", {stimulus, cap_valid, cap_index, busy, done}, 30'd0);
    end
    repeat (3) @(posedge sys_clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge sys_clk);
      #1;
      checks++;
      if ({busy, done, cap_valid} !== 3'b000) begin
        errors++;
        $display("FAIL rst_after_release cyc=%0d got=%b exp=000", i, {busy, done, cap_valid});
      end
    end
    next_tick();
    start = 1'b1;
    next_tick();
    start = 1'b0;
    for (int k = 0; k <= OFF + CAP + 1; k++) begin
      if (k > 0) next_tick();
      exp = model(0, k, 0);
      checks++;
      if ({stimulus, cap_valid, cap_index, busy, done} !== exp) begin
        errors++;
        $display("FAIL rst_rerun k=%0d got=%h exp=%h", k, {stimulus, cap_valid, cap_index, busy, done}, exp);
      end
    end
  endtask

  task automatic test_start_stop_idle();
    next_tick();
    start = 1'b1;
    stop  = 1'b1;
    mode  = 2'($urandom_range(0, 3));
    for (int i = 0; i < 3; i++) begin
      next_tick();
      checks++;
      if ({stimulus, cap_valid, cap_index, busy, done} !== 30'd0) begin
        errors++;
        $display("FAIL start_stop_idle i=%0d got=%h exp=%h", i, {stimulus, cap_valid, cap_index, busy, done}, 30'd0);
      end
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [29:0] exp;
    next_tick();
    mode  = 2'd2;
    start = 1'b1;
    next_tick();
    for (int kk = 0; kk <= OFF + CAP + 1 + OFF + 6; kk++) begin
      if (kk > 0) next_tick();
      exp = (kk <= OFF + CAP) ? model(2, kk, 0) : model(2, kk - (OFF + CAP + 1), 0);
      checks++;
      if ({stimulus, cap_valid, cap_index, busy, done} !== exp) begin
        errors++;
        $display("FAIL b2b kk=%0d got=%h exp=%h", kk, {stimulus, cap_valid, cap_index, busy, done}, exp);
      end
    end
    start = 1'b0;
    stop  = 1'b1;
    next_tick();
    checks++;
    if ({stimulus, cap_valid, busy, done} !== {18'sd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_abort got=%h exp=%h", {stimulus, cap_valid, busy, done}, {18'sd0, 1'b0, 1'b0, 1'b1});
    end
    stop = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    mode  = 2'd0;
    test_reset();
    test_single_impulse();
    test_step();
    test_prbs();
    test_periodic();
    test_reset_mid_run();
    test_start_stop_idle();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/impulse_stim_gen.md
IMPULSE_STIM_GEN -- requirements
Module: impulse_stim_gen

Interface
REQ-001 Parameter WIDTH, 18, stimulus word width (two's complement).
REQ-002 Parameter AMP, 18'sh18000, stimulus amplitude; sign-extended or truncated to WIDTH.
REQ-003 Parameter OFFSET, 29, sample ticks from start acceptance to first active stimulus sample; range 1..PERIOD-1.
REQ-004 Parameter CAP_LEN, 128, capture window length in sample ticks; range 1..PERIOD-OFFSET.
REQ-005 Parameter PERIOD, 512, sample ticks per frame; CW = clog2(PERIOD) counter width.
REQ-006 sys_clk  in  1  system clock; all state changes on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 sam_clk_en  in  1  one-sys_clk-wide sample-rate tick.
REQ-009 sym_clk_en  in  1  one-sys_clk-wide symbol-rate tick, coincident with a sam_clk_en.
REQ-010 start  in  1  level; request a run.
REQ-011 stop  in  1  level; abort run.
REQ-012 mode  in  2  0 single impulse, 1 periodic impulse, 2 step, 3 PRBS 4-level; sampled at start acceptance only.
REQ-013 stimulus  out  WIDTH  registered stimulus sample.
REQ-014 cap_valid  out  1  registered; high during capture window.
REQ-015 cap_index  out  CW  registered; sample index within capture window.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 done  out  1  one-sys_clk pulse at run completion.

Function
REQ-018 States IDLE, LEAD, ACTIVE, TAIL; all transitions and counter updates only on cycles with sam_clk_en=1, except reset and done clearing.
REQ-019 IDLE: start=1 and stop=0 on a tick -> LEAD, frame counter cnt<=0, mode latched; otherwise stay, stimulus=0.
REQ-020 LEAD: cnt increments per tick; on the tick where cnt reaches OFFSET -> ACTIVE, stimulus, cap_valid=1 and cap_index=0 all take effect in that same registered update.
REQ-021 ACTIVE: cap_index increments per tick; after CAP_LEN samples with cap_valid=1, cap_valid<=0 and state -> TAIL (modes 1) or IDLE with done pulse (modes 0, 2, 3).
REQ-022 Mode 0: stimulus=AMP for exactly one sample tick (the first ACTIVE sample), 0 otherwise.
REQ-023 Mode 2: stimulus=AMP for every ACTIVE sample, 0 on exit.
REQ-024 Mode 3: 9-bit LFSR x^9+x^5+1, seed 9'h1FF at start acceptance, advanced on sym_clk_en during ACTIVE; 2 LSBs map 00->+AMP, 01->+AMP/3, 10->-AMP/3, 11->-AMP; stimulus held between symbol ticks; AMP/3 by truncating signed division computed at elaboration.
REQ-025 Mode 1: TAIL counts cnt to PERIOD-1, then wraps cnt to 0 -> LEAD; repeats indefinitely until stop.
REQ-026 stop=1 on a tick in any non-IDLE state -> IDLE, stimulus<=0, cap_valid<=0, done pulse; stop has priority over every other transition.
REQ-027 start while busy is ignored; start held high at completion starts a new run on the next tick after returning to IDLE (not the completion tick).
REQ-028 done: asserted for the single sys_clk cycle following the completing tick, never at sam rate width.
REQ-029 cap_index and cnt never exceed CAP_LEN-1 and PERIOD-1 respectively; no overflow wrap other than REQ-025.

Reset
REQ-030 reset=1 forces IDLE, cnt=0, LFSR=9'h1FF, stimulus=0, cap_valid=0, cap_index=0, busy=0, done=0, immediately and independently of sys_clk.
REQ-031 reset asserted mid-run aborts without done pulse; after release, a new start is required.

Verification
REQ-032 Mode 0, defaults, sam_clk_en every 4 sys_clk: start pulse -> stimulus=18'sh18000 on exactly one sample, 29 ticks after acceptance; cap_valid high 128 ticks, cap_index 0..127; one done pulse.
REQ-033 Mode 1, start held: impulses every 512 sample ticks for 3 frames; stop mid-capture of frame 3 -> stimulus 0, cap_valid 0, done pulse within one tick.
REQ-034 Mode 2: stimulus=AMP for 128 consecutive samples then 0; busy deasserts with done.
REQ-035 Mode 3, sym_clk_en every 4th sam_clk_en: first 8 symbols match the LFSR reference model from seed 9'h1FF; values only in {+-98304, +-32768}.
REQ-036 Reset asserted during ACTIVE: all outputs 0 same cycle, no done pulse; start after release reproduces REQ-032 timing exactly.
REQ-037 start asserted while busy and simultaneous start+stop in IDLE: both ignored, no state change.
